// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: in-order write-back buffer ahead of the register file.
// Drains one queued write per cycle unless the write port is stalled, and
// flags read-after-write hazards against entries still waiting to be written.
// Optional build macro: WB_BYPASS_EN adds rs1_fwd_data/rs2_fwd_data, carrying
// the youngest queued value for each lookup index.
module reg_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_rd,
  input  logic [XLEN-1:0]          in_data,
  input  logic                     wb_stall,
  output logic                     RegWrite,
  output logic [4:0]               rd,
  output logic [XLEN-1:0]          Write_Data,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  output logic                     rs1_pending,
  output logic                     rs2_pending,
`ifdef WB_BYPASS_EN
  output logic [XLEN-1:0]          rs1_fwd_data,
  output logic [XLEN-1:0]          rs2_fwd_data,
`endif
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [4:0]      r_rd    [DEPTH];
  logic [XLEN-1:0] r_data  [DEPTH];
  logic            r_valid [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_full;
  logic            w_accept;
  logic            w_push;
  logic            w_drain;
  logic [DEPTH-1:0] w_rs1_hit;
  logic [DEPTH-1:0] w_rs2_hit;

  // Handshake: a full queue still accepts when the head leaves this cycle.
  // An x0 target completes the handshake but never occupies an entry.
  always_comb begin
    w_full   = (r_count == CW'(DEPTH));
    in_ready = ~w_full | ~wb_stall;
    w_accept = in_valid & in_ready;
    w_push   = w_accept & (in_rd != 5'd0);
    w_drain  = (r_count != '0) & ~wb_stall;
  end

  // Register file port is driven straight from the head entry, zeroed when idle.
  always_comb begin
    RegWrite   = w_drain;
    rd         = w_drain ? r_rd[r_rd_ptr]   : 5'd0;
    Write_Data = w_drain ? r_data[r_rd_ptr] : '0;
    count      = r_count;
  end

  // Storage, pointers and occupancy; drain clears before push so a full-queue
  // pass-through can reuse the slot the head vacates.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_rd[i]    <= 5'd0;
        r_data[i]  <= '0;
      end
    end else begin
      if (w_drain) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + AW'(1);
      end
      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_rd[r_wr_ptr]    <= in_rd;
        r_data[r_wr_ptr]  <= in_data;
        r_wr_ptr          <= r_wr_ptr + AW'(1);
      end
      case ({w_push, w_drain})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Hazard lookup over every live entry, including a head that drains this cycle.
  always_comb begin
    w_rs1_hit = '0;
    w_rs2_hit = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_rs1_hit[i] = r_valid[i] & (r_rd[i] == rs1);
      w_rs2_hit[i] = r_valid[i] & (r_rd[i] == rs2);
    end
    rs1_pending = (rs1 != 5'd0) & (|w_rs1_hit);
    rs2_pending = (rs2 != 5'd0) & (|w_rs2_hit);
  end

`ifdef WB_BYPASS_EN
  logic [AW-1:0]   w_idx;
  logic [XLEN-1:0] w_fwd1;
  logic [XLEN-1:0] w_fwd2;

  // Walk entries oldest to youngest so the last match seen is the youngest.
  always_comb begin
    w_idx  = '0;
    w_fwd1 = '0;
    w_fwd2 = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_idx = r_rd_ptr + AW'(k);
      if (w_rs1_hit[w_idx]) w_fwd1 = r_data[w_idx];
      if (w_rs2_hit[w_idx]) w_fwd2 = r_data[w_idx];
    end
    rs1_fwd_data = rs1_pending ? w_fwd1 : '0;
    rs2_fwd_data = rs2_pending ? w_fwd2 : '0;
  end
`endif

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Testbench for reg_writeback_queue: directed scenarios with literal
// expectations followed by randomized traffic against a queue-based model.
module tb_reg_writeback_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      in_rd;
  logic [XLEN-1:0] in_data;
  logic            wb_stall;
  logic            RegWrite;
  logic [4:0]      rd;
  logic [XLEN-1:0] Write_Data;
  logic [4:0]      rs1, rs2;
  logic            rs1_pending, rs2_pending;
`ifdef WB_BYPASS_EN
  logic [XLEN-1:0] rs1_fwd_data, rs2_fwd_data;
`endif
  logic [2:0]      count;

  always #5 clk = ~clk;

  reg_writeback_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .wb_stall(wb_stall),
    .RegWrite(RegWrite), .rd(rd), .Write_Data(Write_Data),
    .rs1(rs1), .rs2(rs2), .rs1_pending(rs1_pending), .rs2_pending(rs2_pending),
`ifdef WB_BYPASS_EN
    .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
`endif
    .count(count)
  );

  typedef struct packed {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } ent_t;

  ent_t q[$];
  int checks = 0;
  int errors = 0;

  logic            m_push, m_drn, m_rst;
  logic [4:0]      m_rd;
  logic [XLEN-1:0] m_data;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs from the current queue contents and this cycle's inputs.
  task automatic check_model();
    logic            e_ready, e_drn, p1, p2;
    logic [XLEN-1:0] f1, f2;
    int              n;
    n       = q.size();
    e_ready = (n < DEPTH) || !wb_stall;
    e_drn   = (n != 0) && !wb_stall;
    p1 = 1'b0; p2 = 1'b0; f1 = '0; f2 = '0;
    foreach (q[i]) begin
      if (rs1 != 0 && q[i].rd == rs1) begin p1 = 1'b1; f1 = q[i].data; end
      if (rs2 != 0 && q[i].rd == rs2) begin p2 = 1'b1; f2 = q[i].data; end
    end
    chk("count",    64'(count),    64'(n));
    chk("in_ready", 64'(in_ready), 64'(e_ready));
    chk("RegWrite", 64'(RegWrite), 64'(e_drn));
    chk("rd",         64'(rd),         e_drn ? 64'(q[0].rd)   : 64'd0);
    chk("Write_Data", 64'(Write_Data), e_drn ? 64'(q[0].data) : 64'd0);
    chk("rs1_pending", 64'(rs1_pending), 64'(p1));
    chk("rs2_pending", 64'(rs2_pending), 64'(p2));
`ifdef WB_BYPASS_EN
    chk("rs1_fwd", 64'(rs1_fwd_data), 64'(f1));
    chk("rs2_fwd", 64'(rs2_fwd_data), 64'(f2));
`endif
    m_push = in_valid && e_ready && (in_rd != 0);
    m_drn  = e_drn;
    m_rst  = reset;
    m_rd   = in_rd;
    m_data = in_data;
  endtask

  task automatic tick();
    @(posedge clk);
    if (m_rst) q.delete();
    else begin
      if (m_drn) void'(q.pop_front());
      if (m_push) q.push_back('{rd: m_rd, data: m_data});
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] r, input logic [XLEN-1:0] d,
                       input logic s, input logic [4:0] a, input logic [4:0] b,
                       input logic rst);
    in_valid = v; in_rd = r; in_data = d; wb_stall = s;
    rs1 = a; rs2 = b; reset = rst;
    #1;
    check_model();
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 1, 0, 0, 1);
    tick();
  endtask

  initial begin
    reset = 1; in_valid = 0; in_rd = 0; in_data = 0; wb_stall = 1; rs1 = 0; rs2 = 0;
    m_rst = 1; m_push = 0; m_drn = 0; m_rd = 0; m_data = 0;
    tick();

    // 1: single write latency
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t1_reset_count", 64'(count), 64'd0);
    chk("t1_reset_ready", 64'(in_ready), 64'd1);
    chk("t1_reset_regwrite", 64'(RegWrite), 64'd0);
    tick();
    drive(1, 5, 32'hA5, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t1_regwrite", 64'(RegWrite), 64'd1);
    chk("t1_rd", 64'(rd), 64'd5);
    chk("t1_data", 64'(Write_Data), 64'hA5);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t1_regwrite_after", 64'(RegWrite), 64'd0);
    chk("t1_count_after", 64'(count), 64'd0);
    tick();

    // 2: fill under stall, then ordered release
    for (int i = 1; i <= 4; i++) begin
      drive(1, 5'(i), 32'h100 + i, 1, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 1, 0, 0, 0);
    chk("t2_count_full", 64'(count), 64'd4);
    chk("t2_ready_full", 64'(in_ready), 64'd0);
    chk("t2_regwrite_stalled", 64'(RegWrite), 64'd0);
    tick();
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      chk("t2_drain_rd", 64'(rd), 64'(i));
      chk("t2_drain_data", 64'(Write_Data), 64'(32'h100 + i));
      tick();
    end

    // 3: full pass-through across pointer wrap
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 5'(10 + i), 32'h300 + i, 1, 0, 0, 0);
      tick();
    end
    for (int j = 0; j < 6; j++) begin
      drive(1, 5'(20 + j), 32'h200 + j, 0, 0, 0, 0);
      chk("t3_ready", 64'(in_ready), 64'd1);
      chk("t3_count", 64'(count), 64'd4);
      chk("t3_rd", 64'(rd), (j < 4) ? 64'(10 + j) : 64'(20 + j - 4));
      tick();
    end

    // 4: hazard on a twice-written register
    do_reset();
    drive(1, 7, 32'h11, 1, 0, 0, 0); tick();
    drive(1, 7, 32'h22, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 1, 7, 0, 0);
    chk("t4_rs1_pending", 64'(rs1_pending), 64'd1);
    chk("t4_rs2_pending", 64'(rs2_pending), 64'd0);
`ifdef WB_BYPASS_EN
    chk("t4_rs1_fwd", 64'(rs1_fwd_data), 64'h22);
`endif
    tick();

    // 5: x0 target is swallowed
    do_reset();
    drive(1, 0, 32'hFF, 0, 0, 0, 0);
    chk("t5_ready", 64'(in_ready), 64'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("t5_count", 64'(count), 64'd0);
    chk("t5_regwrite", 64'(RegWrite), 64'd0);
    tick();

    // 6: reset discards queued writes
    for (int i = 1; i <= 3; i++) begin
      drive(1, 5'(i), 32'h600 + i, 1, 0, 0, 0);
      tick();
    end
    drive(0, 0, 0, 1, 1, 2, 1);
    chk("t6_count_before", 64'(count), 64'd3);
    tick();
    drive(0, 0, 0, 0, 1, 2, 0);
    chk("t6_count", 64'(count), 64'd0);
    chk("t6_regwrite", 64'(RegWrite), 64'd0);
    chk("t6_pending", 64'({rs1_pending, rs2_pending}), 64'd0);
    tick();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom % 10) < 7,
            (($urandom % 16) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
            $urandom,
            ($urandom % 3) == 0,
            5'($urandom_range(0, 7)),
            5'($urandom_range(0, 7)),
            ($urandom % 250) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
